// File: rtl/ultrasoon_axil_slave.sv
// AXI4-Lite register slave and ultrasonic ranging engine for the Ultrasoon peripheral.
// Define ULTRASOON_ECHO_SYNC_EN to pass ECHO through a 2-flop synchronizer (default: single sample flop).
module ultrasoon_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int HOLDOFF_CYCLES     = 6000000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            TRIG,
    input  logic                            ECHO,
    output logic                            IRQ
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_HOLDOFF   = 3'd5;

    localparam logic [23:0] CNT_MAX     = 24'hFFFFFF;
    localparam logic [23:0] HOLDOFF_LIM = (HOLDOFF_CYCLES < 1) ? 24'd1 :
                                          (HOLDOFF_CYCLES > 16777215) ? 24'hFFFFFF :
                                          24'(HOLDOFF_CYCLES);

    logic [31:0] ctrl_reg, trig_len_reg, timeout_reg;
    logic        res_valid, res_tmo;
    logic [23:0] res_width;
    logic        awready, bvalid, arready, rvalid;
    logic [1:0]  bresp;
    logic [31:0] rdata, rd_word;
    logic        irq_q, trig_q, echo_s;
    logic [2:0]  state;
    logic [23:0] cnt, width;
    logic        pend_tmo;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    wire        enable  = ctrl_reg[0];
    wire [1:0]  wr_sel  = S_AXI_AWADDR[3:2];
    wire [1:0]  rd_sel  = S_AXI_ARADDR[3:2];
    wire        wr_fire = awready && S_AXI_AWVALID && S_AXI_WVALID;
    wire        rd_fire = arready && S_AXI_ARVALID;
    wire        done_fire = (state == S_DONE) && enable;

    wire [23:0] cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 24'd1;
    wire [23:0] width_inc = (width == CNT_MAX) ? width : width + 24'd1;
    wire [23:0] tmo_lim   = timeout_reg[23:0];
    wire [23:0] trig_lim  = (|trig_len_reg[31:24]) ? CNT_MAX :
                            (trig_len_reg[23:0] == 24'd0) ? 24'd1 : trig_len_reg[23:0];

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) v[8*i +: 8] = new_val[8*i +: 8];
        return v;
    endfunction

`ifdef ULTRASOON_ECHO_SYNC_EN
    logic [1:0] echo_sync;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) echo_sync <= 2'b00;
        else        echo_sync <= {echo_sync[0], ECHO};
    end
    assign echo_s = echo_sync[1];
`else
    logic echo_q;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) echo_q <= 1'b0;
        else        echo_q <= ECHO;
    end
    assign echo_s = echo_q;
`endif

    // Write channel: AW and W are accepted together, and only while no response is outstanding.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready      <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= 2'b00;
            ctrl_reg     <= 32'h0;
            trig_len_reg <= 32'h000003E8;
            timeout_reg  <= 32'h002DC6C0;
        end else begin
            awready <= !awready && !bvalid && S_AXI_AWVALID && S_AXI_WVALID;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= (wr_sel == 2'd3) ? 2'b10 : 2'b00;
                case (wr_sel)
                    2'd0:    ctrl_reg     <= apply_strb(ctrl_reg, S_AXI_WDATA, S_AXI_WSTRB);
                    2'd1:    trig_len_reg <= apply_strb(trig_len_reg, S_AXI_WDATA, S_AXI_WSTRB);
                    2'd2:    timeout_reg  <= apply_strb(timeout_reg, S_AXI_WDATA, S_AXI_WSTRB);
                    default: ;
                endcase
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        case (rd_sel)
            2'd0: rd_word = ctrl_reg;
            2'd1: rd_word = trig_len_reg;
            2'd2: rd_word = timeout_reg;
            2'd3: rd_word = {res_valid, res_tmo, 6'b0, res_width};
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            arready <= !arready && !rvalid && S_AXI_ARVALID;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    // A fresh result takes priority over the read-to-clear of IRQ.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            res_valid <= 1'b0;
            res_tmo   <= 1'b0;
            res_width <= 24'h0;
            irq_q     <= 1'b0;
        end else if (done_fire) begin
            res_valid <= 1'b1;
            res_tmo   <= pend_tmo;
            res_width <= width;
            irq_q     <= 1'b1;
        end else if (rd_fire && rd_sel == 2'd3) begin
            irq_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= S_IDLE;
            cnt      <= 24'h0;
            width    <= 24'h0;
            pend_tmo <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            trig_q <= (state == S_TRIG) && enable;
            if (!enable) begin
                state <= S_IDLE;
                cnt   <= 24'h0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_TRIG;
                        cnt   <= 24'h0;
                    end
                    S_TRIG: begin
                        if (cnt_inc >= trig_lim) begin
                            state <= S_WAIT_RISE;
                            cnt   <= 24'h0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_WAIT_RISE: begin
                        if (echo_s) begin
                            if (tmo_lim <= 24'd1) begin
                                state    <= S_DONE;
                                pend_tmo <= 1'b1;
                                width    <= tmo_lim;
                            end else begin
                                state    <= S_MEASURE;
                                pend_tmo <= 1'b0;
                                width    <= 24'd1;
                            end
                        end else if (cnt_inc >= tmo_lim) begin
                            state    <= S_DONE;
                            pend_tmo <= 1'b1;
                            width    <= 24'h0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_MEASURE: begin
                        if (!echo_s) begin
                            state    <= S_DONE;
                            pend_tmo <= 1'b0;
                        end else if (width_inc >= tmo_lim) begin
                            state    <= S_DONE;
                            pend_tmo <= 1'b1;
                            width    <= tmo_lim;
                        end else begin
                            width <= width_inc;
                        end
                    end
                    S_DONE: begin
                        state <= S_HOLDOFF;
                        cnt   <= 24'h0;
                    end
                    S_HOLDOFF: begin
                        if (cnt_inc >= HOLDOFF_LIM) state <= S_IDLE;
                        else                        cnt   <= cnt_inc;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = awready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign TRIG          = trig_q;
    assign IRQ           = irq_q;

endmodule

// File: tb/tb_ultrasoon_axil_slave.sv
// Scoreboard bench for ultrasoon_axil_slave: register access, ranging, timeout and B-channel stall.
module tb_ultrasoon_axil_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, echo = 0;
    logic [31:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid, trig, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_resp_q[$];

    always #5 clk = ~clk;

    ultrasoon_axil_slave #(.HOLDOFF_CYCLES(300)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .TRIG(trig), .ECHO(echo), .IRQ(irq)
    );

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        if (!(awready && wready)) begin
            checks++; errors++;
            $display("[TB] FAIL aw_timeout addr=%h awready=%b wready=%b required=1", addr, awready, wready);
            awvalid = 0; wvalid = 0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("[TB] FAIL b_timeout addr=%h bvalid=%b required=1", addr, bvalid);
            bready = 0;
            return;
        end
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin
            checks++; errors++;
            $display("[TB] FAIL ar_timeout addr=%h arready=%b required=1", addr, arready);
            arvalid = 0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("[TB] FAIL r_timeout addr=%h rvalid=%b required=1", addr, rvalid);
            rready = 0;
            return;
        end
        data = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d, ed;
        logic [1:0]  r;
        logic [3:0]  a;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (trig !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig got=%b exp=0", trig); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_handshake got=%b exp=00000", {awready, wready, arready, bvalid, rvalid});
        end
        exp_data_q.push_back(32'h00000000);
        exp_data_q.push_back(32'h000003E8);
        exp_data_q.push_back(32'h002DC6C0);
        exp_data_q.push_back(32'h00000000);
        for (int i = 0; i < 4; i++) begin
            a = 4'(i * 4);
            exp_resp_q.push_back(2'b00);
            axi_read(a, d, r);
            ed = exp_data_q.pop_front();
            checks++;
            if (d !== ed) begin errors++; $display("[TB] FAIL reset_read addr=%h got=%h exp=%h", a, d, ed); end
            checks++;
            if (r !== exp_resp_q[0]) begin errors++; $display("[TB] FAIL reset_rresp addr=%h got=%b exp=%b", a, r, exp_resp_q[0]); end
            void'(exp_resp_q.pop_front());
        end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        exp_resp_q.push_back(2'b00);
        axi_write(4'h4, 32'h00000010, 4'hF, r);
        er = exp_resp_q.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("[TB] FAIL strb_bresp1 got=%b exp=%b", r, er); end
        exp_resp_q.push_back(2'b00);
        axi_write(4'h4, 32'h0000AB00, 4'h2, r);
        er = exp_resp_q.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("[TB] FAIL strb_bresp2 got=%b exp=%b", r, er); end
        exp_data_q.push_back(32'h0000AB10);
        axi_read(4'h4, d, r);
        ed = exp_data_q.pop_front();
        checks++;
        if (d !== ed) begin errors++; $display("[TB] FAIL strb_read got=%h exp=%h", d, ed); end
    endtask

    task automatic test_read_only();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        exp_resp_q.push_back(2'b10);
        axi_write(4'hC, 32'hFFFFFFFF, 4'hF, r);
        er = exp_resp_q.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("[TB] FAIL ro_bresp got=%b exp=%b", r, er); end
        exp_data_q.push_back(32'h00000000);
        axi_read(4'hC, d, r);
        ed = exp_data_q.pop_front();
        checks++;
        if (d !== ed) begin errors++; $display("[TB] FAIL ro_read got=%h exp=%h", d, ed); end
    endtask

    task automatic test_measurement();
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        int n, hi;
        exp_resp_q.push_back(2'b00);
        axi_write(4'h4, 32'd10, 4'hF, r);
        exp_resp_q.push_back(2'b00);
        axi_write(4'h0, 32'h1, 4'hF, r);
        er = exp_resp_q.pop_front();
        er = exp_resp_q.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("[TB] FAIL meas_enable_bresp got=%b exp=%b", r, er); end
        n = 0;
        do begin @(negedge clk); n++; end while (!trig && n < 100);
        hi = 0;
        while (trig && hi < 1000) begin hi++; @(negedge clk); end
        checks++;
        if (hi != 10) begin errors++; $display("[TB] FAIL trig_width got=%0d exp=10", hi); end
        @(posedge clk); #1 echo = 1;
        repeat (100) @(posedge clk);
        #1 echo = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!irq && n < 100);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL meas_irq got=%b exp=1", irq); end
        exp_resp_q.push_back(2'b00);
        axi_write(4'h0, 32'h0, 4'hF, r);
        er = exp_resp_q.pop_front();
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_after_disable got=%b exp=1", irq); end
        exp_data_q.push_back(32'h80000064);
        axi_read(4'hC, d, r);
        ed = exp_data_q.pop_front();
        checks++;
        if (d !== ed) begin errors++; $display("[TB] FAIL meas_result got=%h exp=%h", d, ed); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL meas_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, ed;
        logic [1:0]  r;
        int n;
        axi_write(4'h8, 32'd50, 4'hF, r);
        axi_write(4'h0, 32'h1, 4'hF, r);
        n = 0;
        do begin @(negedge clk); n++; end while (!trig && n < 100);
        n = 0;
        while (trig && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!irq && n < 200);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL tmo_irq got=%b exp=1", irq); end
        checks++;
        if (n < 50 || n > 52) begin errors++; $display("[TB] FAIL tmo_latency got=%0d exp=50..52", n); end
        axi_write(4'h0, 32'h0, 4'hF, r);
        exp_data_q.push_back(32'hC0000000);
        axi_read(4'hC, d, r);
        ed = exp_data_q.pop_front();
        checks++;
        if (d !== ed) begin errors++; $display("[TB] FAIL tmo_result got=%h exp=%h", d, ed); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL tmo_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d, ed;
        logic [1:0]  r;
        int n, hold_bad, aw_bad;
        @(posedge clk); #1;
        awaddr = 4'h0; wdata = 32'h12345670; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin
            checks++; errors++;
            $display("[TB] FAIL bp_aw_timeout awready=%b required=1", awready);
            awvalid = 0; wvalid = 0;
            return;
        end
        @(posedge clk); #1;
        wdata = 32'hA5A5A5A4;
        hold_bad = 0; aw_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid !== 1'b1) hold_bad++;
            if (awready !== 1'b0) aw_bad++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("[TB] FAIL bp_bvalid_hold dropped_cycles=%0d exp=0", hold_bad); end
        checks++;
        if (aw_bad != 0) begin errors++; $display("[TB] FAIL bp_aw_blocked awready_cycles=%0d exp=0", aw_bad); end
        @(posedge clk); #1 bready = 1;
        @(posedge clk); #1 bready = 0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_bvalid_clear got=%b exp=0", bvalid); end
        checks++;
        if (awready !== 1'b0) begin errors++; $display("[TB] FAIL bp_aw_early got=%b exp=0", awready); end
        @(negedge clk);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("[TB] FAIL bp_aw_after_b got=%b exp=1", awready); end
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin awvalid = 0; wvalid = 0; return; end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 bready = 0;
        exp_data_q.push_back(32'hA5A5A5A4);
        axi_read(4'h0, d, r);
        ed = exp_data_q.pop_front();
        checks++;
        if (d !== ed) begin errors++; $display("[TB] FAIL bp_second_write got=%h exp=%h", d, ed); end
    endtask

    initial begin
        test_reset();
        test_byte_strobes();
        test_read_only();
        test_measurement();
        test_timeout();
        test_back_pressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ultrasoon_axil_slave.md
# ultrasoon_axil_slave

AXI4-Lite slave responder for the Ultrasoon IP: answers the master's single-beat reads and writes on a four-word register map and runs an ultrasonic ranging engine. The engine drives the sensor trigger pin and measures the echo pulse width in clock cycles. It sits behind the interconnect as the S00_AXI endpoint of the Ultrasoon peripheral, with TRIG/ECHO routed to package pins.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
- HOLDOFF_CYCLES, 6000000, idle cycles between measurements in continuous mode.
- ACLK  in  1  single clock, all logic rising-edge.
- ARESET  in  1  reset, asynchronous and active-high.
- S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- TRIG  out  1  sensor trigger pulse.
- ECHO  in  1  sensor echo, asynchronous to ACLK.
- IRQ  out  1  level interrupt: a new result is available.

## Operation
- Register map:
  - 0x00 CTRL rw, reset 0. Bit0 ENABLE runs continuous measurement. Other bits are stored and read back.
  - 0x04 TRIG_LEN rw, reset 0x000003E8.
  - 0x08 TIMEOUT rw, reset 0x002DC6C0. Only bits [23:0] are used.
  - 0x0C RESULT ro, reset 0. Bit31 VALID, bit30 TIMEOUT, [23:0] width in cycles. Bits 29:24 read 0.
- Writes apply WSTRB per byte. A write to 0x0C changes nothing and returns BRESP=SLVERR (2'b10). All other writes return OKAY.
- Reads always return RRESP=OKAY. A read of 0x0C clears IRQ and does not clear RESULT.
- AWPROT/ARPROT are ignored.
- Engine states and transitions:
  - IDLE: go to TRIG when ENABLE=1.
  - TRIG: TRIG=1 for TRIG_LEN cycles; TRIG_LEN=0 counts as 1. Then go to WAIT_RISE.
  - WAIT_RISE: wait for sampled ECHO=1, counting cycles. If the count reaches TIMEOUT, go to DONE with TIMEOUT=1 and width=0.
  - MEASURE: width counts every cycle sampled ECHO=1. On sampled ECHO=0, go to DONE. If width reaches TIMEOUT, go to DONE with TIMEOUT=1 and width=TIMEOUT.
  - DONE: write RESULT with VALID=1, set IRQ, then go to HOLDOFF.
  - HOLDOFF: wait HOLDOFF_CYCLES, then go to IDLE.
- Counters are 24-bit and saturate; they never wrap.
- ENABLE cleared in any state: the engine goes to IDLE at the next edge, TRIG=0, RESULT and IRQ unchanged.
- A read of RESULT in the same cycle DONE writes a new result: the new result wins and IRQ stays 1.
- ARESET asserted mid-operation: all registers, engine state and outputs go to reset values immediately.

## Timing
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, TRIG=0, IRQ=0.
- Write:
  - When AWVALID and WVALID are both sampled high and BVALID=0, AWREADY and WREADY pulse together for exactly one cycle.
  - The register updates on the handshake edge; BVALID rises on that same edge.
  - BVALID holds until BREADY is sampled high. No new AW/W is accepted while BVALID=1.
- Read:
  - When ARVALID is sampled high and RVALID=0, ARREADY pulses for one cycle.
  - RVALID and RDATA are registered on the handshake edge and held, stable, until RREADY is sampled high.
- Simultaneous read and write handshakes are both allowed. A read of the same register returns the pre-write value.
- TRIG rises one cycle after the engine enters TRIG and is high for exactly max(TRIG_LEN,1) cycles.
- IRQ rises on the edge the engine leaves DONE.

## Configuration
- ULTRASOON_ECHO_SYNC_EN defined: ECHO passes through a 2-flop synchronizer, adding 2 cycles of detection latency. Measured width is unchanged.
- Undefined: ECHO is sampled directly through 1 flop, with 1 cycle of latency. This is for benches with a synchronous ECHO only.

## Test plan
- Reset: release ARESET, then read 0x00/0x04/0x08/0x0C -> 0x00000000 / 0x000003E8 / 0x002DC6C0 / 0x00000000, all RRESP=OKAY; TRIG=0, IRQ=0.
- Byte strobes: write 0x04=0x00000010 WSTRB=0xF, then 0x0000AB00 WSTRB=0x2 -> read 0x04 returns 0x0000AB10.
- Read-only: write 0x0C=0xFFFFFFFF -> BRESP=SLVERR; read 0x0C returns 0x00000000.
- Measurement: TRIG_LEN=10, ENABLE=1, ECHO high for 100 cycles after TRIG falls -> TRIG high for exactly 10 cycles; RESULT=0x80000064; IRQ=1; reading 0x0C drops IRQ to 0.
- Timeout: TIMEOUT=50, ECHO held 0 -> RESULT=0xC0000000 and IRQ=1, 50 cycles after TRIG falls (plus sync latency).
- Back-pressure: hold BREADY=0 for 5 cycles -> BVALID stays 1; a second AW/W presented meanwhile gets no AWREADY until 1 cycle after the B handshake.
